// File: rtl/hazard_unit.sv
// hazard_unit: shadow tag pipeline driving operand forwarding selects and load-use stalls
module hazard_unit #(
    parameter int NFWD = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W = 16,
    localparam int FSW = $clog2(NFWD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_redirect,
    input  logic             ext_stall,
    output logic [FSW-1:0]   fwda,
    output logic [FSW-1:0]   fwdb,
    output logic             stall,
    output logic             nostall,
    output logic             id_commit,
    output logic             redirect_ok,
    output logic [CNT_W-1:0] stall_cnt
);
    logic [NFWD:1]  v;
    logic [4:0]     rn [1:NFWD];
    logic [FSW-1:0] rdy [1:NFWD];
    logic [FSW:0]   ra, rb;

    // Youngest match decides; an unready youngest match is a hazard with no fall-back.
    function automatic logic [FSW:0] resolve(input logic [4:0] src);
        logic [FSW:0] r;
        r = '0;
        for (int k = NFWD; k >= 1; k--)
            if (v[k] && rn[k] == src && src != 5'd0)
                r = (rdy[k] <= FSW'(k)) ? {1'b0, FSW'(k)} : {1'b1, {FSW{1'b0}}};
        return r;
    endfunction

    always_comb begin
        ra = resolve(id_rs);
        rb = resolve(id_rt);
        fwda = ra[FSW-1:0];
        fwdb = rb[FSW-1:0];
        stall = id_valid & ((id_use_rs & ra[FSW]) | (id_use_rt & rb[FSW]));
        nostall = ~stall;
        id_commit = id_valid & ~stall & ~ext_stall;
        redirect_ok = id_redirect & ~stall & ~ext_stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            stall_cnt <= '0;
        end else if (!ext_stall) begin
            v[1] <= id_commit & id_wreg & (id_rn != 5'd0);
            rn[1] <= id_rn;
            rdy[1] <= id_m2reg ? FSW'(1 + LOAD_LAT) : FSW'(1);
            for (int k = 2; k <= NFWD; k++) begin
                v[k] <= v[k-1];
                rn[k] <= rn[k-1];
                rdy[k] <= rdy[k-1];
            end
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard detection and forwarding controller for the pipelined MIPS core. It replaces the fixed two-stage EXE/MEM forwarding logic with an internal shadow pipeline of destination tags, NFWD stages deep. It supports configurable load latency, multi-cycle load-use stalls, a global external freeze and a saturating stall-cycle counter. It sits beside the ID stage, takes decoded operand and destination info from the decoder, and drives the operand-forwarding mux selects and the pipeline hold/commit controls.

## Interface
Parameters:
- `NFWD`, 3, number of post-ID stages that can forward: stage 1 = EXE, 2 = MEM, 3 = WB, …; range 2..7.
- `LOAD_LAT`, 1, first stage index minus 1 at which load data is forwardable; range 1..NFWD-1.
- `CNT_W`, 16, stall counter width.
- `FSW`, derived as $clog2(NFWD+1), width of a forward select.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_wreg` in 1: ID instruction writes the register file.
- `id_m2reg` in 1: ID instruction is a load.
- `id_rn` in 5: ID destination register.
- `id_rs`, `id_rt` in 5 each: ID source registers.
- `id_use_rs`, `id_use_rt` in 1 each: the source is actually read.
- `id_redirect` in 1: ID resolved a taken branch/jump.
- `ext_stall` in 1: memory system busy; freeze the whole pipeline.
- `fwda`, `fwdb` out FSW: 0 = register file; k = result bus of stage k.
- `stall` out 1: load-use stall; hold PC/IF/ID and inject a bubble into EXE.
- `nostall` out 1: ~stall.
- `id_commit` out 1: id_valid & ~stall & ~ext_stall; gates wreg/wmem.
- `redirect_ok` out 1: id_redirect & ~stall & ~ext_stall; gates pcsource.
- `stall_cnt` out CNT_W: saturating count of load-use stall cycles.

## Operation
- Tag entry at stage k (k = 1..NFWD): {v, rn[4:0], rdy}, where rdy is the stage index from which the result is forwardable.
  - ALU writers: rdy = 1.
  - Loads: rdy = 1 + LOAD_LAT.
- Entry insertion into stage 1 on an unfrozen edge:
  - If id_commit & id_wreg & (id_rn != 0): load {1, id_rn, rdy}.
  - Otherwise stage 1 becomes invalid (bubble).
- Shift: stage k ← stage k-1 on every edge with ~ext_stall. The entry leaving stage NFWD is dropped; its value is in the register file from then on.
- Freeze: ext_stall = 1 holds all tags and stall_cnt. id_commit and redirect_ok are forced to 0.
- Operand resolution, done independently for rs→fwda and rt→fwdb:
  - Find the smallest k with v & rn == src & src != 0.
  - No match → fwd = 0.
  - Match with rdy ≤ k → fwd = k.
  - Match with rdy > k → operand hazard, and fwd = 0 (don't care). There is no fall-back to an older match.
- stall = (id_valid & id_use_rs & hazard_rs) | (id_valid & id_use_rt & hazard_rt).
- A source that is not used never stalls, but fwd is still computed.
- Register 0 never matches. Writers to r0 are not inserted.
- Simultaneous id_redirect & stall: redirect_ok = 0. The redirect is retaken once the stall clears.
- stall_cnt increments on each edge with stall & ~ext_stall & ~rst, and saturates at 2^CNT_W-1 (no wrap).

## Timing
- fwda, fwdb, stall, nostall, id_commit and redirect_ok are combinational from the current tags and ID inputs. There is no added latency.
- Tags update on the rising clk edge.
- A load followed by a dependent instruction stalls for LOAD_LAT cycles. Once the load has advanced to stage 1+LOAD_LAT, the select is fwd = 1+LOAD_LAT.
- Reset (synchronous, takes priority over ext_stall):
  - All tags are invalid and stall_cnt = 0.
  - Consequently fwda = fwdb = 0 and stall = 0 the cycle after reset.
  - id_commit and redirect_ok simply follow their inputs.
- Reset asserted mid-stall: the stall drops the cycle after, and the held load tag is discarded.

## Test plan
- **ALU back-to-back** (defaults): commit add r3. Next cycle ID = sub with rs=r3 → fwda=1, stall=0. Cycle after that → fwda=2, then 3, then 0.
- **Load-use**: commit lw r5. Next cycle ID = add with rt=r5, use_rt=1 → stall=1 for 1 cycle and stage 1 gets a bubble. Then fwdb=2, stall=0, stall_cnt=1.
- **LOAD_LAT=2, NFWD=4**: lw r7 followed by a dependent instruction → stall=1 for 2 consecutive cycles, then fwda=3, stall_cnt=2.
- **r0 and youngest-wins**: writers to r4 at stages 1 and 2, ID rs=r4 → fwda=1. ID rs=r0 with a pending writer to r0 → fwda=0, stall=0.
- **ext_stall freeze**: during a load-use stall, hold ext_stall=1 for 3 cycles → tags are unchanged, stall_cnt is unchanged, and id_commit = redirect_ok = 0. After release the stall resolves as in the load-use scenario.
- **Reset and saturation**: with CNT_W=2, force 5 stall cycles → stall_cnt=3. Assert rst with a pending load → next cycle stall_cnt=0, fwda=fwdb=0, stall=0.
